// File: rtl/urv_mem_model_pkg.sv
// urv_mem_model_pkg
//   Shared types and constants for the uRV bench memory model:
//   DM handshake state encoding, LFSR feedback taps and the default
//   console TX byte address.
package urv_mem_model_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_t;

   // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
   localparam logic [15:0] LFSR_TAPS            = 16'hB400;
   localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0010_0000;

endpackage

// File: rtl/urv_lfsr16.sv
// urv_lfsr16
//   Free-running 16-bit Galois LFSR used to derive deterministic stall and
//   wait-state patterns.
//   Ports:
//     clk_i   in  1   clock
//     rst_n_i in  1   asynchronous active-low reset (loads SEED)
//     q_o     out 16  current LFSR state
module urv_lfsr16
   import urv_mem_model_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic [15:0] q_o
);

   logic [15:0] r_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_q <= SEED;
      end else begin
         r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : '0);
      end
   end

   assign q_o = r_q;

endmodule

// File: rtl/urv_mem_model.sv
// urv_mem_model
//   Shared instruction/data memory for uRV CPU benches. One word array
//   serves a registered IM read port (with LFSR-driven bubbles) and a DM
//   port run by an IDLE/WAIT/RESP handshake FSM with configurable
//   deterministic latency. Byte stores to CONSOLE_ADDR are diverted to a
//   console byte stream instead of the array.
//   Ports:
//     clk_i, rst_n_i             clock, asynchronous active-low reset
//     im_addr_i / im_data_o      instruction byte address / word (1-cycle)
//     im_valid_o                 im_data_o valid (low on injected bubble)
//     dm_addr_i, dm_data_s_i     data byte address, store data
//     dm_data_select_i           store byte enables
//     dm_store_i, dm_load_i      store / load request
//     dm_data_l_o                load data (updated with load done)
//     dm_store_done_o            one-cycle store completion pulse
//     dm_load_done_o             one-cycle load completion pulse
//     con_data_o, con_valid_o    console byte and its strobe
module urv_mem_model
   import urv_mem_model_pkg::*;
#(
   parameter int unsigned MEM_WORDS     = 16384,
   parameter string       INIT_FILE     = "",
   parameter int unsigned IM_STALL_THR  = 0,
   parameter int unsigned DM_LATENCY    = 0,
   parameter int unsigned DM_EXTRA_MASK = 0,
   parameter logic [31:0] CONSOLE_ADDR  = DEFAULT_CONSOLE_ADDR,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] im_addr_i,
   output logic [31:0] im_data_o,
   output logic        im_valid_o,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_store_i,
   input  logic        dm_load_i,
   output logic [31:0] dm_data_l_o,
   output logic        dm_store_done_o,
   output logic        dm_load_done_o,
   output logic [7:0]  con_data_o,
   output logic        con_valid_o
);

   localparam int unsigned IDXW       = $clog2(MEM_WORDS);
   localparam logic [7:0]  STALL_THR  = IM_STALL_THR[7:0];
   localparam logic [7:0]  EXTRA_MASK = DM_EXTRA_MASK[7:0];
   localparam logic [31:0] BASE_WAIT  = DM_LATENCY;

   logic [31:0]     r_mem [MEM_WORDS];

   logic [15:0]     w_lfsr;
   logic [IDXW-1:0] w_im_idx;
   logic [IDXW-1:0] w_dm_idx;
   logic            w_is_con;
   logic            w_accept;
   logic [31:0]     w_wcnt_init;
   logic [31:0]     w_wcnt_nxt;
   dm_state_t       w_state_nxt;
   logic            w_unused;

   dm_state_t       r_state;
   logic [31:0]     r_wcnt;
   logic [31:0]     r_addr;
   logic [31:0]     r_wdata;
   logic [3:0]      r_sel;
   logic            r_is_store;
   logic [31:0]     r_im_data;
   logic            r_im_valid;
   logic [31:0]     r_dm_rdata;
   logic            r_st_done;
   logic            r_ld_done;
   logic [7:0]      r_con_data;
   logic            r_con_valid;

   urv_lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .q_o     (w_lfsr)
   );

   // Upper address bits wrap, byte offset is ignored.
   assign w_im_idx    = im_addr_i[IDXW+1:2];
   assign w_dm_idx    = r_addr[IDXW+1:2];
   assign w_is_con    = (r_addr == CONSOLE_ADDR);
   assign w_wcnt_init = BASE_WAIT + {24'd0, w_lfsr[15:8] & EXTRA_MASK};
   assign w_unused    = ^{im_addr_i[31:IDXW+2], im_addr_i[1:0]};

   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (dm_store_i || dm_load_i) begin
               w_accept    = 1'b1;
               w_wcnt_nxt  = w_wcnt_init;
               w_state_nxt = (w_wcnt_init != '0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            w_wcnt_nxt = r_wcnt - 32'd1;
            if (r_wcnt == 32'd1) begin
               w_state_nxt = RESP;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= IDLE;
         r_wcnt      <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_sel       <= '0;
         r_is_store  <= 1'b0;
         r_im_data   <= '0;
         r_im_valid  <= 1'b0;
         r_dm_rdata  <= '0;
         r_st_done   <= 1'b0;
         r_ld_done   <= 1'b0;
         r_con_data  <= '0;
         r_con_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wcnt     <= w_wcnt_nxt;
         r_im_data  <= r_mem[w_im_idx];
         r_im_valid <= !(w_lfsr[7:0] < STALL_THR);
         // A store presented together with a load wins; the load is dropped.
         if (w_accept) begin
            r_addr     <= dm_addr_i;
            r_wdata    <= dm_data_s_i;
            r_sel      <= dm_data_select_i;
            r_is_store <= dm_store_i;
         end
         r_st_done   <= (r_state == RESP) && r_is_store;
         r_ld_done   <= (r_state == RESP) && !r_is_store;
         r_con_valid <= (r_state == RESP) && r_is_store && w_is_con;
         if ((r_state == RESP) && r_is_store && w_is_con) begin
            r_con_data <= r_wdata[7:0];
         end
         if ((r_state == RESP) && !r_is_store) begin
            r_dm_rdata <= w_is_con ? '0 : r_mem[w_dm_idx];
         end
      end
   end

   // Array is never reset; commit uses the captured request so the IM port
   // reading the same word this edge still sees the old contents.
   always_ff @(posedge clk_i) begin
      if ((r_state == RESP) && r_is_store && !w_is_con) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (r_sel[b]) begin
               r_mem[w_dm_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_n_i && (r_state == IDLE)) begin
         assert (!(dm_store_i && dm_load_i))
            else $error("urv_mem_model: simultaneous store and load, load dropped");
      end
   end

   assign im_data_o       = r_im_data;
   assign im_valid_o      = r_im_valid;
   assign dm_data_l_o     = r_dm_rdata;
   assign dm_store_done_o = r_st_done;
   assign dm_load_done_o  = r_ld_done;
   assign con_data_o      = r_con_data;
   assign con_valid_o     = r_con_valid;

endmodule

// File: tb/tb_urv_mem_model.sv
// tb_urv_mem_model
//   Directed bench for urv_mem_model. Instance 0: zero stall/latency.
//   Instance 1: IM_STALL_THR=128, DM_LATENCY=3. Instance 2: DM_LATENCY=5.
module tb_urv_mem_model;

   logic        clk;
   logic        rst_n    [3];
   logic [31:0] im_addr  [3];
   logic [31:0] im_data  [3];
   logic        im_valid [3];
   logic [31:0] dm_addr  [3];
   logic [31:0] dm_wdata [3];
   logic [3:0]  dm_sel   [3];
   logic        dm_st    [3];
   logic        dm_ld    [3];
   logic [31:0] ld_data  [3];
   logic        st_done  [3];
   logic        ld_done  [3];
   logic [7:0]  con_d    [3];
   logic        con_v    [3];

   int n_cmp = 0;
   int n_bad = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      urv_mem_model #(
         .MEM_WORDS     (16384),
         .IM_STALL_THR  ((g == 1) ? 128 : 0),
         .DM_LATENCY    ((g == 1) ? 3 : ((g == 2) ? 5 : 0)),
         .DM_EXTRA_MASK (0),
         .CONSOLE_ADDR  (32'h0010_0000),
         .LFSR_SEED     (16'hACE1)
      ) u_dut (
         .clk_i            (clk),
         .rst_n_i          (rst_n[g]),
         .im_addr_i        (im_addr[g]),
         .im_data_o        (im_data[g]),
         .im_valid_o       (im_valid[g]),
         .dm_addr_i        (dm_addr[g]),
         .dm_data_s_i      (dm_wdata[g]),
         .dm_data_select_i (dm_sel[g]),
         .dm_store_i       (dm_st[g]),
         .dm_load_i        (dm_ld[g]),
         .dm_data_l_o      (ld_data[g]),
         .dm_store_done_o  (st_done[g]),
         .dm_load_done_o   (ld_done[g]),
         .con_data_o       (con_d[g]),
         .con_valid_o      (con_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Issue one DM request and report the cycles to its done pulse, the done
   // level one cycle later, and the outputs seen on the done cycle.
   task automatic dm_op(input int u, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sel,
                        output int lat, output logic done_next,
                        output logic [31:0] rd, output logic cv,
                        output logic [7:0] cd, output logic [31:0] imd);
      @(negedge clk);
      dm_addr[u]  = a;
      dm_wdata[u] = d;
      dm_sel[u]   = sel;
      dm_st[u]    = st;
      dm_ld[u]    = !st;
      @(posedge clk); #1;
      dm_st[u]    = 1'b0;
      dm_ld[u]    = 1'b0;
      dm_addr[u]  = ~a;
      dm_wdata[u] = ~d;
      dm_sel[u]   = ~sel;
      lat = -1; rd = 'x; cv = 1'bx; cd = 'x; imd = 'x;
      for (int k = 1; k <= 64; k++) begin
         @(posedge clk); #1;
         if (st ? st_done[u] : ld_done[u]) begin
            lat = k; rd = ld_data[u]; cv = con_v[u]; cd = con_d[u]; imd = im_data[u];
            break;
         end
      end
      @(posedge clk); #1;
      done_next = st ? st_done[u] : ld_done[u];
   endtask

   int          lat;
   logic        dn;
   logic [31:0] rd;
   logic        cv;
   logic [7:0]  cd;
   logic [31:0] imd;

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (im_data[0] !== 32'h0) begin n_bad++; $display("FAIL rst_im_data got=%h exp=%h", im_data[0], 32'h0); end
      n_cmp++; if (im_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rst_im_valid got=%b exp=0", im_valid[0]); end
      n_cmp++; if (ld_data[0] !== 32'h0) begin n_bad++; $display("FAIL rst_ld_data got=%h exp=%h", ld_data[0], 32'h0); end
      n_cmp++; if ({st_done[0], ld_done[0], con_v[0]} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes got=%b exp=000", {st_done[0], ld_done[0], con_v[0]}); end
      n_cmp++; if (con_d[0] !== 8'h0) begin n_bad++; $display("FAIL rst_con_data got=%h exp=00", con_d[0]); end
      n_cmp++; if (im_valid[1] !== 1'b0) begin n_bad++; $display("FAIL rst_im_valid_b got=%b exp=0", im_valid[1]); end
      @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[2] = 1'b1;
   endtask

   task automatic test_im_zero_stall();
      dm_op(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL preload_lat got=%0d exp=1", lat); end
      @(negedge clk);
      im_addr[0] = 32'h40;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         n_cmp++; if ({im_valid[0], im_data[0]} !== {1'b1, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL im_read[%0d] got=%b/%h exp=1/deadbeef", i, im_valid[0], im_data[0]);
         end
      end
      // store to the word IM is reading: old value on the commit edge, new after
      dm_op(0, 1'b1, 32'h40, 32'h0BADC0DE, 4'hF, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (imd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL im_rbw_old got=%h exp=deadbeef", imd); end
      n_cmp++; if (im_data[0] !== 32'h0BADC0DE) begin n_bad++; $display("FAIL im_rbw_new got=%h exp=0badc0de", im_data[0]); end
   endtask

   task automatic test_byte_lane();
      dm_op(0, 1'b1, 32'h80, 32'h11223344, 4'hF, lat, dn, rd, cv, cd, imd);
      dm_op(0, 1'b1, 32'h80, 32'hAABBCCDD, 4'b0101, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL bl_store_lat got=%0d exp=1", lat); end
      n_cmp++; if (dn !== 1'b0) begin n_bad++; $display("FAIL bl_store_width got=%b exp=0", dn); end
      dm_op(0, 1'b0, 32'h80, 32'h0, 4'h0, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL bl_load_lat got=%0d exp=1", lat); end
      n_cmp++; if (dn !== 1'b0) begin n_bad++; $display("FAIL bl_load_width got=%b exp=0", dn); end
      n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL bl_data got=%h exp=11bb33dd", rd); end
   endtask

   task automatic test_console();
      dm_op(0, 1'b1, 32'h0, 32'h5A5A0001, 4'hF, lat, dn, rd, cv, cd, imd);
      dm_op(0, 1'b1, 32'h0010_0000, 32'h00000041, 4'b0001, lat, dn, rd, cv, cd, imd);
      n_cmp++; if ({cv, cd} !== {1'b1, 8'h41}) begin n_bad++; $display("FAIL con_byte got=%b/%h exp=1/41", cv, cd); end
      n_cmp++; if (con_v[0] !== 1'b0) begin n_bad++; $display("FAIL con_width got=%b exp=0", con_v[0]); end
      dm_op(0, 1'b0, 32'h0010_0000, 32'h0, 4'h0, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL con_load got=%h exp=00000000", rd); end
      dm_op(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (rd !== 32'h5A5A0001) begin n_bad++; $display("FAIL con_no_array got=%h exp=5a5a0001", rd); end
   endtask

   task automatic test_wrap();
      dm_op(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (rd !== 32'h5A5A0001) begin n_bad++; $display("FAIL wrap_w0 got=%h exp=5a5a0001", rd); end
      dm_op(0, 1'b0, 32'h0001_0042, 32'h0, 4'h0, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (rd !== 32'h0BADC0DE) begin n_bad++; $display("FAIL wrap_w10 got=%h exp=0badc0de", rd); end
   endtask

   task automatic test_stall();
      logic [15:0] m;
      int cnt_dut;
      int cnt_ref;
      m = 16'hACE1; cnt_dut = 0; cnt_ref = 0;
      @(negedge clk);
      rst_n[1] = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk); #1;
         if (im_valid[1] === 1'b0) cnt_dut++;
         if (m[7:0] < 8'd128) cnt_ref++;
         m = m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
      end
      n_cmp++; if (cnt_dut !== cnt_ref) begin n_bad++; $display("FAIL stall_count got=%0d exp=%0d", cnt_dut, cnt_ref); end
   endtask

   task automatic test_latency();
      dm_op(1, 1'b1, 32'h100, 32'h76543210, 4'hF, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL lat3_store got=%0d exp=4", lat); end
      dm_op(1, 1'b0, 32'h100, 32'h0, 4'h0, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL lat3_load got=%0d exp=4", lat); end
      n_cmp++; if (dn !== 1'b0) begin n_bad++; $display("FAIL lat3_width got=%b exp=0", dn); end
      n_cmp++; if (rd !== 32'h76543210) begin n_bad++; $display("FAIL lat3_data got=%h exp=76543210", rd); end
   endtask

   task automatic test_reset_midop();
      int pulses;
      dm_op(2, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL lat5_store got=%0d exp=6", lat); end
      @(negedge clk);
      dm_addr[2] = 32'h40; dm_wdata[2] = 32'h12345678; dm_sel[2] = 4'hF; dm_st[2] = 1'b1;
      @(posedge clk); #1;
      dm_st[2] = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n[2] = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (st_done[2] !== 1'b0 || ld_done[2] !== 1'b0) pulses++;
      end
      @(negedge clk);
      rst_n[2] = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (st_done[2] !== 1'b0 || ld_done[2] !== 1'b0) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
      dm_op(2, 1'b0, 32'h40, 32'h0, 4'h0, lat, dn, rd, cv, cd, imd);
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL midrst_load_lat got=%0d exp=6", lat); end
      n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL midrst_data got=%h exp=cafef00d", rd); end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i]    = 1'b0;
         im_addr[i]  = '0;
         dm_addr[i]  = '0;
         dm_wdata[i] = '0;
         dm_sel[i]   = '0;
         dm_st[i]    = 1'b0;
         dm_ld[i]    = 1'b0;
      end
      test_reset();
      test_im_zero_stall();
      test_byte_lane();
      test_console();
      test_wrap();
      test_stall();
      test_latency();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
